// File: rtl/fpcvt_pkg.sv
// Shared definitions for the floating-point style encode/decode converters:
// default field widths and the sequencer state encoding.
package fpcvt_pkg;

    localparam int W_D_DEF = 12;
    localparam int W_E_DEF = 3;
    localparam int W_F_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negation of a W-bit word.
module twos_negate #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = ~a + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/fp_decode_seq.sv
// Sequential decoder of a sign/exponent/significand triple into a
// two's-complement word D = (-1)^S * F * 2^E, one left shift per cycle.
module fp_decode_seq
    import fpcvt_pkg::*;
#(
    parameter int W_D = W_D_DEF,
    parameter int W_E = W_E_DEF,
    parameter int W_F = W_F_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           S,
    input  logic [W_E-1:0] E,
    input  logic [W_F-1:0] F,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_D-1:0] D
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE,
    // and D is held stable while out_valid waits for out_ready.

    state_t         state;
    logic           sign;
    logic [W_D-1:0] acc;
    logic [W_E-1:0] cnt;
    logic [W_D-1:0] acc_neg;

    twos_negate #(.W(W_D)) u_negate (
        .a(acc),
        .y(acc_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sign      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            D         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= S;
                        acc      <= {{(W_D-W_F){1'b0}}, F};
                        cnt      <= E;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - W_E'(1);
                    end else begin
                        // Negating a zero magnitude yields zero, so -0 decodes to 0.
                        D         <= sign ? acc_neg : acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_decode_seq.sv
// Directed bench for fp_decode_seq: hand-computed conversions, latency,
// backpressure hold and reset in the middle of a conversion.
module tb_fp_decode_seq;

    localparam int W_D = 12;
    localparam int W_E = 3;
    localparam int W_F = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           S;
    logic [W_E-1:0] E;
    logic [W_F-1:0] F;
    logic           out_valid;
    logic           out_ready;
    logic [W_D-1:0] D;

    int checks = 0;
    int errors = 0;
    logic [W_D-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    fp_decode_seq #(.W_D(W_D), .W_E(W_E), .W_F(W_F)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .S(S),
        .E(E),
        .F(F),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D(D)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: launch one conversion and wait for the result
    task automatic run_conv(input logic s, input logic [W_E-1:0] e, input logic [W_F-1:0] f,
                            input logic [W_D-1:0] exp_d, input string name);
        int lat;
        @(negedge clk);
        check_eq({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        S = s;
        E = e;
        F = f;
        exp_q.push_back(exp_d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        S = 1'($urandom_range(0, 1));
        E = W_E'($urandom_range(0, 7));
        F = W_F'($urandom_range(0, 15));
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({name, " latency"}, 32'(lat), 32'(e) + 32'd1);
        check_eq({name, " D"}, 32'(D), 32'(exp_q.pop_front()));
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({name, " drain in_ready"}, 32'(in_ready), 32'd1);
        check_eq({name, " drain out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S         = 1'b0;
        E         = '0;
        F         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset D", 32'(D), 32'd0);

        run_conv(1'b0, 3'd0, 4'd5,  12'h005, "e0_f5");   drain("e0_f5");
        run_conv(1'b0, 3'd2, 4'd9,  12'h024, "e2_f9");   drain("e2_f9");
        run_conv(1'b0, 3'd7, 4'd15, 12'h780, "max_pos"); drain("max_pos");
        run_conv(1'b1, 3'd7, 4'd15, 12'h880, "max_neg"); drain("max_neg");
        run_conv(1'b1, 3'd5, 4'd0,  12'h000, "neg_zero"); drain("neg_zero");
        run_conv(1'b1, 3'd0, 4'd1,  12'hfff, "minus_one"); drain("minus_one");
        run_conv(1'b1, 3'd3, 4'd6,  12'hfd0, "neg_48"); drain("neg_48");

        // backpressure: DONE must hold while inputs wiggle
        run_conv(1'b0, 3'd2, 4'd9, 12'h024, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            S = 1'($urandom_range(0, 1));
            E = W_E'($urandom_range(0, 7));
            F = W_F'($urandom_range(1, 15));
            @(posedge clk);
            #1;
            check_eq("bp hold D", 32'(D), 32'h024);
            check_eq("bp hold out_valid", 32'(out_valid), 32'd1);
            check_eq("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        drain("bp");
        check_eq("bp D after drain", 32'(D), 32'h024);

        // reset two cycles into an E=7 conversion, with valid/ready also high
        @(negedge clk);
        in_valid = 1'b1;
        S = 1'b0;
        E = 3'd7;
        F = 4'd15;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_eq("mid rst in_ready", 32'(in_ready), 32'd1);
        check_eq("mid rst out_valid", 32'(out_valid), 32'd0);
        check_eq("mid rst D", 32'(D), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("mid rst no output", 32'(seen), 32'd0);
        run_conv(1'b0, 3'd1, 4'd3, 12'h006, "after_rst");
        drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
